// File: rtl/uart_piso_tx.sv
// ----------------------------------------------------------------------------
// uart_piso_tx
//   Parallel-in / serial-out stage that sits directly after the UART framer.
//   On a send request in IDLE it captures the 11-bit framed word together
//   with the frame length implied by parity_type / data_length / stop_bits,
//   then shifts the word LSB-first onto tx_out. Each bit is held for
//   CLKS_PER_BIT clocks. tx_out, active and done are all registered.
//
//   Optional feature (compile-time macro PISO_GUARD_BIT_EN):
//     defined   -> after the last bit the FSM spends CLKS_PER_BIT clocks in a
//                  GUARD state (line high, send ignored) before IDLE, which
//                  guarantees one idle bit time between frames.
//     undefined -> the FSM returns straight to IDLE after the last bit.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit time (>= 2)
//   CNT_W         baud counter width, 2**CNT_W >= CLKS_PER_BIT
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active low
//   frame_in     in   [10:0] framed word, bit0 = start bit
//   parity_type  in   [1:0] 01 odd, 10 even, 00/11 none
//   data_length  in   0 = 7 data bits, 1 = 8 data bits
//   stop_bits    in   0 = 1 stop bit, 1 = 2 stop bits
//   send         in   level request, only looked at in IDLE
//   tx_out       out  serial line, idles high
//   active       out  high while a frame is being shifted out
//   done         out  one-clock pulse at frame completion
// ----------------------------------------------------------------------------
module uart_piso_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] frame_in,
    input  logic [1:0]  parity_type,
    input  logic        data_length,
    input  logic        stop_bits,
    input  logic        send,
    output logic        tx_out,
    output logic        active,
    output logic        done
);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TX    = 2'd1
`ifdef PISO_GUARD_BIT_EN
        ,
        S_GUARD = 2'd2
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [10:0]       shreg_q, shreg_d;     // bits still to be sent, next at [0]
    logic [3:0]        len_q, len_d;         // latched frame length N
    logic [3:0]        bit_cnt_q, bit_cnt_d; // index of the bit now on the line
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic              tx_q, tx_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    // Frame length: start + data + optional parity + stop bits (9..12).
    function automatic logic [3:0] frame_len(input logic [1:0] pt,
                                             input logic       dl,
                                             input logic       sb);
        logic [3:0] n;
        n = 4'd1 + (dl ? 4'd8 : 4'd7)
                 + ((pt == 2'b01 || pt == 2'b10) ? 4'd1 : 4'd0)
                 + (sb ? 4'd2 : 4'd1);
        return n;
    endfunction

    logic last_bit;
    logic baud_wrap;

    assign baud_wrap = (baud_cnt_q == BAUD_LAST);
    assign last_bit  = (bit_cnt_q == (len_q - 4'd1));

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        tx_d       = tx_q;
        active_d   = active_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
                if (send) begin
                    // Start bit goes out on the accepting edge; the rest of
                    // the word waits in the shift register. The top is
                    // back-filled with 1 so a 12th bit reads as a stop bit.
                    shreg_d    = {1'b1, frame_in[10:1]};
                    len_d      = frame_len(parity_type, data_length, stop_bits);
                    tx_d       = frame_in[0];
                    active_d   = 1'b1;
                    baud_cnt_d = '0;
                    bit_cnt_d  = 4'd0;
                    state_d    = S_TX;
                end
            end

            S_TX: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (last_bit) begin
                        tx_d     = 1'b1;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        shreg_d  = '1;
`ifdef PISO_GUARD_BIT_EN
                        state_d  = S_GUARD;
`else
                        state_d  = S_IDLE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b1, shreg_q[10:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

`ifdef PISO_GUARD_BIT_EN
            // One full bit time of idle line; baud_cnt was cleared on entry.
            S_GUARD: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d  = S_IDLE;
                tx_d     = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '1;
            len_q      <= 4'd0;
            bit_cnt_q  <= 4'd0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign active = active_q;
    assign done   = done_q;

endmodule
